// File: rtl/touch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : touch_pkg
// Description : Shared constants and helpers for the touch event generator.
// Revision    : 1.0 - initial release
// ============================================================================
package touch_pkg;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_deb  = 2'd1;
    localparam logic [1:0] c_emit = 2'd2;
    localparam logic [1:0] c_wrel = 2'd3;

    // Panel extent; coordinates at or beyond these are off-panel.
    localparam logic [15:0] c_x_max = 16'd800;
    localparam logic [15:0] c_y_max = 16'd480;

    function automatic logic [31:0] pack_xy(input logic [15:0] x, input logic [15:0] y);
        return {x, y};
    endfunction

endpackage
`default_nettype wire

// File: rtl/touch_win_cmp.sv
`default_nettype none
// ============================================================================
// Module      : touch_win_cmp
// Description : Combinational jitter-window check of a sample against a reference.
// Revision    : 1.0 - initial release
// ============================================================================
module touch_win_cmp #(
    parameter int JITTER = 8
) (
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic [15:0] i_rx,
    input  logic [15:0] i_ry,
    output logic        o_in_win
);

    logic signed [16:0] w_dx;
    logic signed [16:0] w_dy;
    logic        [16:0] w_adx;
    logic        [16:0] w_ady;

    // 17-bit signed differences keep the full 16-bit span without wrapping.
    always_comb begin
        w_dx     = $signed({1'b0, i_x}) - $signed({1'b0, i_rx});
        w_dy     = $signed({1'b0, i_y}) - $signed({1'b0, i_ry});
        w_adx    = w_dx[16] ? 17'(-w_dx) : 17'(w_dx);
        w_ady    = w_dy[16] ? 17'(-w_dy) : 17'(w_dy);
        o_in_win = (w_adx <= 17'(JITTER)) && (w_ady <= 17'(JITTER));
    end

endmodule
`default_nettype wire

// File: rtl/touch_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : touch_event_gen
// Description : Debounces touch-panel samples into one touch_valid pulse per press.
//               Define TOUCH_AVG_EN to report the average of the debounce samples.
// Revision    : 1.0 - initial release
// ============================================================================
module touch_event_gen
    import touch_pkg::*;
#(
    parameter int          DEB_CNT      = 4,
    parameter int          REL_CNT      = 3,
    parameter int          PULSE_CYCLES = 5,
    parameter int          JITTER       = 8,
    parameter logic [15:0] X_MAX        = c_x_max,
    parameter logic [15:0] Y_MAX        = c_y_max
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        raw_vld,
    input  logic        raw_press,
    input  logic [15:0] raw_x,
    input  logic [15:0] raw_y,
    output logic        touch_valid,
    output logic [31:0] data,
    output logic        busy
);

    localparam logic [3:0] c_deb_last   = 4'(DEB_CNT - 1);
    localparam logic [3:0] c_rel_last   = 4'(REL_CNT - 1);
    localparam logic [7:0] c_pulse_last = 8'(PULSE_CYCLES - 1);

    logic [1:0]  r_state;
    logic [15:0] r_ref_x;
    logic [15:0] r_ref_y;
    logic [3:0]  r_deb_cnt;
    logic [3:0]  r_rel_cnt;
    logic [7:0]  r_pulse_cnt;
    logic        r_valid;
    logic [31:0] r_data;

    logic        w_pressed;
    logic        w_released;
    logic        w_in_win;
    logic [31:0] w_emit_data;

    assign w_pressed  = raw_vld & raw_press & (raw_x < X_MAX) & (raw_y < Y_MAX);
    assign w_released = raw_vld & ~w_pressed;

    touch_win_cmp #(
        .JITTER (JITTER)
    ) u_win_cmp (
        .i_x      (raw_x),
        .i_y      (raw_y),
        .i_rx     (r_ref_x),
        .i_ry     (r_ref_y),
        .o_in_win (w_in_win)
    );

`ifdef TOUCH_AVG_EN
    localparam int c_shift = $clog2(DEB_CNT);

    logic [19:0] r_acc_x;
    logic [19:0] r_acc_y;
    logic [19:0] w_sum_x;
    logic [19:0] w_sum_y;

    // The final in-window sample is folded in combinationally at emit time.
    assign w_sum_x     = r_acc_x + 20'(raw_x);
    assign w_sum_y     = r_acc_y + 20'(raw_y);
    assign w_emit_data = pack_xy(16'(w_sum_x >> c_shift), 16'(w_sum_y >> c_shift));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_x <= 20'd0;
            r_acc_y <= 20'd0;
        end else if (w_pressed && (r_state == c_idle || (r_state == c_deb && !w_in_win))) begin
            r_acc_x <= 20'(raw_x);
            r_acc_y <= 20'(raw_y);
        end else if (w_pressed && r_state == c_deb) begin
            r_acc_x <= w_sum_x;
            r_acc_y <= w_sum_y;
        end
    end
`else
    assign w_emit_data = pack_xy(r_ref_x, r_ref_y);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_idle;
            r_ref_x     <= 16'd0;
            r_ref_y     <= 16'd0;
            r_deb_cnt   <= 4'd0;
            r_rel_cnt   <= 4'd0;
            r_pulse_cnt <= 8'd0;
            r_valid     <= 1'b0;
            r_data      <= 32'd0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_pressed) begin
                        r_ref_x   <= raw_x;
                        r_ref_y   <= raw_y;
                        r_deb_cnt <= 4'd1;
                        r_state   <= c_deb;
                    end
                end
                c_deb: begin
                    if (w_pressed && w_in_win) begin
                        if (r_deb_cnt == c_deb_last) begin
                            r_data      <= w_emit_data;
                            r_valid     <= 1'b1;
                            r_pulse_cnt <= c_pulse_last;
                            r_deb_cnt   <= 4'd0;
                            r_state     <= c_emit;
                        end else begin
                            r_deb_cnt <= r_deb_cnt + 4'd1;
                        end
                    end else if (w_pressed) begin
                        r_ref_x   <= raw_x;
                        r_ref_y   <= raw_y;
                        r_deb_cnt <= 4'd1;
                    end else if (w_released) begin
                        r_deb_cnt <= 4'd0;
                        r_state   <= c_idle;
                    end
                end
                c_emit: begin
                    if (r_pulse_cnt == 8'd0) begin
                        r_valid   <= 1'b0;
                        r_rel_cnt <= 4'd0;
                        r_state   <= c_wrel;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt - 8'd1;
                    end
                end
                c_wrel: begin
                    if (w_released) begin
                        if (r_rel_cnt == c_rel_last) begin
                            r_rel_cnt <= 4'd0;
                            r_state   <= c_idle;
                        end else begin
                            r_rel_cnt <= r_rel_cnt + 4'd1;
                        end
                    end else if (w_pressed) begin
                        r_rel_cnt <= 4'd0;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign touch_valid = r_valid;
    assign data        = r_data;
    assign busy        = (r_state != c_idle);

endmodule
`default_nettype wire

// File: tb/tb_touch_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_touch_event_gen
// Description : Directed, table-driven bench for touch_event_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_touch_event_gen;

    typedef struct {
        logic        vld;
        logic        press;
        logic [15:0] x;
        logic [15:0] y;
        logic        exp_valid;
        logic        exp_busy;
        logic [31:0] exp_data;
    } vec_t;

    localparam logic [31:0] c_d1 = 32'h0064_0064;
    localparam logic [31:0] c_d2 = 32'h0258_0190;
    localparam logic [31:0] c_d3 = 32'h012C_0135;
    localparam logic [31:0] c_d4 = 32'h0032_003C;

    logic        clk;
    logic        rst;
    logic        raw_vld;
    logic        raw_press;
    logic [15:0] raw_x;
    logic [15:0] raw_y;
    logic        touch_valid;
    logic [31:0] data;
    logic        busy;

    int   n_checks;
    int   n_errors;
    vec_t tbl[$];

    touch_event_gen dut (
        .clk         (clk),
        .rst         (rst),
        .raw_vld     (raw_vld),
        .raw_press   (raw_press),
        .raw_x       (raw_x),
        .raw_y       (raw_y),
        .touch_valid (touch_valid),
        .data        (data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add(input logic v, input logic p, input int x, input int y,
                       input logic ev, input logic eb, input logic [31:0] ed);
        vec_t r;
        r.vld = v; r.press = p; r.x = 16'(x); r.y = 16'(y);
        r.exp_valid = ev; r.exp_busy = eb; r.exp_data = ed;
        tbl.push_back(r);
    endtask

    // Pressed sample, released sample, idle cycle.
    task automatic ap(input int x, input int y, input logic ev, input logic eb, input logic [31:0] ed);
        add(1'b1, 1'b1, x, y, ev, eb, ed);
    endtask
    task automatic ar(input logic ev, input logic eb, input logic [31:0] ed);
        add(1'b1, 1'b0, 0, 0, ev, eb, ed);
    endtask
    task automatic an(input logic ev, input logic eb, input logic [31:0] ed);
        add(1'b0, 1'b0, 0, 0, ev, eb, ed);
    endtask

    task automatic step(input logic v, input logic p, input int x, input int y);
        raw_vld   = v;
        raw_press = p;
        raw_x     = 16'(x);
        raw_y     = 16'(y);
        @(posedge clk);
        #1;
    endtask

    int pulses;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        raw_vld   = 1'b0;
        raw_press = 1'b0;
        raw_x     = 16'd0;
        raw_y     = 16'd0;
        #3;
        chk("reset valid", {31'd0, touch_valid}, 32'd0);
        chk("reset busy",  {31'd0, busy},        32'd0);
        chk("reset data",  data,                 32'd0);
        #9;
        rst = 1'b0;

        // T1: clean press, 5-cycle pulse, re-arm after 3 releases
        for (int i = 0; i < 3; i++) ap(100, 100, 1'b0, 1'b1, 32'd0);
        ap(100, 100, 1'b1, 1'b1, c_d1);
        for (int i = 0; i < 4; i++) ar(1'b1, 1'b1, c_d1);
        ar(1'b0, 1'b1, c_d1);
        ar(1'b0, 1'b1, c_d1);
        ar(1'b0, 1'b1, c_d1);
        ar(1'b0, 1'b0, c_d1);

        // T3: too short a press
        for (int i = 0; i < 3; i++) ap(200, 200, 1'b0, 1'b1, c_d1);
        ar(1'b0, 1'b0, c_d1);
        an(1'b0, 1'b0, c_d1);

        // T2: reference moves on the third sample
        ap(450, 400, 1'b0, 1'b1, c_d1);
        ap(452, 398, 1'b0, 1'b1, c_d1);
        ap(600, 400, 1'b0, 1'b1, c_d1);
        ap(600, 401, 1'b0, 1'b1, c_d1);
        ap(601, 400, 1'b0, 1'b1, c_d1);
        ap(600, 400, 1'b1, 1'b1, c_d2);
        for (int i = 0; i < 4; i++) an(1'b1, 1'b1, c_d2);
        an(1'b0, 1'b1, c_d2);
        ar(1'b0, 1'b1, c_d2);
        ar(1'b0, 1'b1, c_d2);
        ar(1'b0, 1'b0, c_d2);

        // Window edge: 8 inclusive, 9 outside; press during WREL restarts release count
        ap(300, 300, 1'b0, 1'b1, c_d2);
        ap(308, 292, 1'b0, 1'b1, c_d2);
        ap(300, 309, 1'b0, 1'b1, c_d2);
        ap(300, 309, 1'b0, 1'b1, c_d2);
        ap(300, 309, 1'b0, 1'b1, c_d2);
        ap(300, 309, 1'b1, 1'b1, c_d3);
        for (int i = 0; i < 4; i++) an(1'b1, 1'b1, c_d3);
        an(1'b0, 1'b1, c_d3);
        ar(1'b0, 1'b1, c_d3);
        ar(1'b0, 1'b1, c_d3);
        ap(300, 300, 1'b0, 1'b1, c_d3);
        ar(1'b0, 1'b1, c_d3);
        ar(1'b0, 1'b1, c_d3);
        ar(1'b0, 1'b0, c_d3);

        // T5: off-panel samples count as released; (799,479) is on-panel
        for (int i = 0; i < 3; i++) ap(820, 100, 1'b0, 1'b0, c_d3);
        ap(100, 480, 1'b0, 1'b0, c_d3);
        ap(800, 0,   1'b0, 1'b0, c_d3);
        ap(799, 479, 1'b0, 1'b1, c_d3);
        ar(1'b0, 1'b0, c_d3);

        // raw_vld=0 cycles are ignored during debounce
        ap(50, 60, 1'b0, 1'b1, c_d3);
        add(1'b0, 1'b1, 50, 60, 1'b0, 1'b1, c_d3);
        ap(50, 60, 1'b0, 1'b1, c_d3);
        ap(50, 60, 1'b0, 1'b1, c_d3);
        ap(50, 60, 1'b1, 1'b1, c_d4);
        for (int i = 0; i < 4; i++) an(1'b1, 1'b1, c_d4);
        an(1'b0, 1'b1, c_d4);
        ar(1'b0, 1'b1, c_d4);
        ar(1'b0, 1'b1, c_d4);
        ar(1'b0, 1'b0, c_d4);

        foreach (tbl[i]) begin
            step(tbl[i].vld, tbl[i].press, int'(tbl[i].x), int'(tbl[i].y));
            chk($sformatf("row%0d valid", i), {31'd0, touch_valid}, {31'd0, tbl[i].exp_valid});
            chk($sformatf("row%0d busy", i),  {31'd0, busy},        {31'd0, tbl[i].exp_busy});
            chk($sformatf("row%0d data", i),  data,                 tbl[i].exp_data);
        end

        // T4: finger held for 40 samples gives exactly one event
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 100, 400);
            if (touch_valid) pulses++;
            chk($sformatf("hold busy %0d", i), {31'd0, busy}, 32'd1);
        end
        chk("hold pulse cycles", pulses, 32'd5);
        chk("hold data", data, 32'h0064_0190);
        step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        chk("hold busy rel2", {31'd0, busy}, 32'd1);
        step(1'b1, 1'b0, 0, 0);
        chk("hold busy rel3", {31'd0, busy}, 32'd0);

        // T6: reset during the third EMIT cycle
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 100, 100);
        chk("t6 rise", {31'd0, touch_valid}, 32'd1);
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        chk("t6 third cycle", {31'd0, touch_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6 async valid", {31'd0, touch_valid}, 32'd0);
        chk("t6 async data",  data,                 32'd0);
        chk("t6 async busy",  {31'd0, busy},        32'd0);
        #3 rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 200, 100);
            if (touch_valid) pulses++;
        end
        chk("t6 no early pulse", pulses, 32'd0);
        step(1'b1, 1'b1, 200, 100);
        chk("t6 second rise", {31'd0, touch_valid}, 32'd1);
        chk("t6 second data", data, 32'h00C8_0064);
        pulses = 1;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 0, 0);
            if (touch_valid) pulses++;
        end
        chk("t6 second pulse cycles", pulses, 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
